exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Execution sequencer driving the iteration counter of each PE tile. Accepts an iteration configuration and loop bounds from the host over a valid/ready handshake and writes them into the counter. On `go` it runs the start-up sequence, then steps the configuration-memory address and vector sub-counter. It raises the gated-clock enable for the counter domain and terminates the run when the counter reports `exec_end`.

## Interface
- `CONFIG_MEM_BITS`, 3: config-memory address bits; address bus is `CONFIG_MEM_BITS+1` wide.
- `ITER_RANGE_BITS`, 32: width of the iteration maxCount field.
- `STRIDE_BITS`, 2: width of the stride field.
- `CONFIG_WIDTH`, `STRIDE_BITS+ITER_RANGE_BITS`: width of the configuration word as {stride, maxCount}.
- `VEC_WIDTH`, 4: vector lanes; `VEC_WIDTH_BITS = $clog2(VEC_WIDTH)` (localparam).
- `FLUSH_CYCLES`, 2: number of post-run cycles that keep `clken_vec` high.

Ports:
- `clk  in  1`: clock.
- `rstn  in  1`: asynchronous active-low reset.
- `chip_en  in  1`: global enable; when low, all state and counters hold.
- `cfg_valid  in  1`, `cfg_ready  out  1`: host configuration handshake.
- `cfg_data  in  CONFIG_WIDTH`: configuration word to load.
- `cfg_loop_start  in  CONFIG_MEM_BITS+1`, `cfg_loop_end  in  CONFIG_MEM_BITS`: loop bounds, captured with `cfg_data`.
- `cfg_vec_size  in  VEC_WIDTH_BITS`: vector size minus 1, captured with `cfg_data`.
- `go  in  1`, `abort  in  1`: single-cycle command pulses.
- `busy  out  1`, `done  out  1`: status; `done` is a one-cycle pulse.
- `run_cycles  out  32`: number of RUN cycles in the last run.
- `configuration  out  CONFIG_WIDTH`, `wr_en  out  1`: configuration write to the counter.
- `loop_end  out  CONFIG_MEM_BITS`, `vec_size  out  VEC_WIDTH_BITS`: registered copies of the captured bounds.
- `start_exec  out  1`, `start_exec_shifted  out  1`: execution phase strobes.
- `addr_cmem  out  CONFIG_MEM_BITS+1`, `vec_counter  out  VEC_WIDTH_BITS`: configuration-memory address and vector sub-counter.
- `clken_vec  out  1`: enable for the counter-domain clock gate.
- `exec_end  in  1`: end of iterations, from the counter.

## Operation
- Reset values: state IDLE. `cfg_ready=1`, `clken_vec=1`. All other outputs and registers are 0, including `loaded`.
- **IDLE.** `cfg_ready=1`.
  - Handshake (`cfg_valid && cfg_ready && chip_en`) captures `cfg_data` and the three bound inputs, sets `loaded`, and moves to LOAD.
  - `go && loaded` moves to START.
  - `go` without `loaded` is ignored.
  - If a handshake and `go` occur together, the handshake wins.
- **LOAD** (1 cycle). `wr_en=1`, `configuration`=captured word, `cfg_ready=0`. Returns to IDLE.
- **START** (1 cycle). `start_exec=1`, `start_exec_shifted=0`. Sets `addr_cmem<=loop_start`, `vec_counter<=0` and `run_cycles<=0`. Moves to RUN.
- **RUN.** `start_exec=1`, `start_exec_shifted=1`, `busy=1`, and `run_cycles` increments every cycle, saturating at all-ones.
  - `vec_counter` counts 0..`vec_size`, then wraps to 0.
  - `clken_vec = (vec_counter==vec_size)`.
  - When `clken_vec` is high, `addr_cmem` updates: if `addr_cmem>=loop_end` or `addr_cmem<loop_start`, it loads `loop_start`; otherwise it increments.
  - `exec_end` sampled high moves to FLUSH.
  - Comparisons are unsigned; `loop_end` is zero-extended to the address width.
- **FLUSH** (`FLUSH_CYCLES` cycles). All strobes are 0, `clken_vec=1`, `busy=1`, and `addr_cmem` and `vec_counter` are cleared. This lets the counter domain return to its idle values. Moves to DONE.
- **DONE** (1 cycle). `done=1`. Moves to IDLE. `loaded` stays set, so `go` reruns the same configuration.
- `abort` in START or RUN moves to FLUSH on the next cycle. `abort` has priority over `exec_end`. In other states `abort` is ignored.
- With `chip_en=0`: state, counters and `run_cycles` hold, and `wr_en`, `done` and `cfg_ready` are forced to 0. Strobes keep their values.
- `busy=1` in LOAD, START, RUN and FLUSH.

## Timing
- All outputs are registered except `cfg_ready`, `busy` and `clken_vec`, which decode directly from state and `vec_counter`.
- Handshake at cycle N gives `wr_en=1` at N+1.
- `go` at cycle N gives `start_exec` rising at N+1 and `start_exec_shifted` rising at N+2.
- `exec_end` high at cycle N gives strobes low at N+1, FLUSH during N+1..N+`FLUSH_CYCLES`, and `done` at N+`FLUSH_CYCLES`+1.
- Reset asserted mid-run returns every output to its reset value immediately, asynchronously; `loaded` is cleared.

## Structure
- Shared package `exec_seq_pkg`: state enum `seq_state_e` {IDLE, LOAD, START, RUN, FLUSH, DONE} and default parameter constants.
- One sub-module, `loop_addr_gen`: the `vec_counter` and `addr_cmem` wrap logic with its clear and step controls.

## Test plan
- Load `cfg_data=34'h1_0000_0007` → `wr_en` pulses exactly one cycle after the handshake with `configuration=34'h1_0000_0007`, and `cfg_ready` is low in that cycle.
- `go` with `loop_start=1`, `loop_end=3`, `vec_size=0` → `start_exec` at +1, `start_exec_shifted` at +2, then `addr_cmem` runs 1,2,3,1,2,3 with `clken_vec` continuously high.
- `vec_size=3` → `vec_counter` runs 0,1,2,3,0 and `clken_vec` is high one cycle in four; `addr_cmem` steps only on those cycles.
- Drive `exec_end` after 10 RUN cycles → 2 FLUSH cycles with `clken_vec=1`, then a one-cycle `done` pulse, and `run_cycles=10`.
- `go` before any configuration load → no state change and `busy` stays 0. `abort` in RUN → strobes drop the next cycle, followed by FLUSH and `done`.
- Drop `chip_en` for 3 cycles in RUN → `addr_cmem`, `vec_counter` and `run_cycles` are frozen. Assert `rstn=0` in RUN → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared types and defaults for the PE-tile execution sequencer.
package exec_seq_pkg;

  localparam int CONFIG_MEM_BITS_DEF = 3;
  localparam int ITER_RANGE_BITS_DEF = 32;
  localparam int STRIDE_BITS_DEF     = 2;
  localparam int VEC_WIDTH_DEF       = 4;
  localparam int FLUSH_CYCLES_DEF    = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/exec_sequencer_loop_addr_gen.sv
// Vector sub-counter and config-memory address wrap logic.
module loop_addr_gen #(
  parameter int AW = 4,
  parameter int VW = 2,
  parameter int EW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] loop_start_i,
  input  logic [EW-1:0] loop_end_i,
  input  logic [VW-1:0] vec_size_i,
  output logic [AW-1:0] addr_o,
  output logic [VW-1:0] vec_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [VW-1:0] vec_q, vec_d;

  assign last_o = (vec_q == vec_size_i);
  assign addr_o = addr_q;
  assign vec_o  = vec_q;

  // Next address/lane: clear wins over load, load over step; address moves only on the last lane.
  always_comb begin
    addr_d = addr_q;
    vec_d  = vec_q;
    if (clear_i) begin
      addr_d = '0;
      vec_d  = '0;
    end else if (load_i) begin
      addr_d = loop_start_i;
      vec_d  = '0;
    end else if (step_i) begin
      if (last_o) begin
        vec_d = '0;
        if ((addr_q >= AW'(loop_end_i)) || (addr_q < loop_start_i))
          addr_d = loop_start_i;
        else
          addr_d = addr_q + AW'(1);
      end else begin
        vec_d = vec_q + VW'(1);
      end
    end
  end

  // Counter registers, frozen while the chip is disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      vec_q  <= '0;
    end else if (en_i) begin
      addr_q <= addr_d;
      vec_q  <= vec_d;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: loads the iteration counter config, runs it, flushes and reports done.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int CONFIG_MEM_BITS = CONFIG_MEM_BITS_DEF,
  parameter int ITER_RANGE_BITS = ITER_RANGE_BITS_DEF,
  parameter int STRIDE_BITS     = STRIDE_BITS_DEF,
  parameter int CONFIG_WIDTH    = STRIDE_BITS + ITER_RANGE_BITS,
  parameter int VEC_WIDTH       = VEC_WIDTH_DEF,
  parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
  localparam int VEC_WIDTH_BITS = $clog2(VEC_WIDTH),
  localparam int AW             = CONFIG_MEM_BITS + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       chip_en,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CONFIG_WIDTH-1:0]    cfg_data,
  input  logic [AW-1:0]              cfg_loop_start,
  input  logic [CONFIG_MEM_BITS-1:0] cfg_loop_end,
  input  logic [VEC_WIDTH_BITS-1:0]  cfg_vec_size,
  input  logic                       go,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                run_cycles,
  output logic [CONFIG_WIDTH-1:0]    configuration,
  output logic                       wr_en,
  output logic [CONFIG_MEM_BITS-1:0] loop_end,
  output logic [VEC_WIDTH_BITS-1:0]  vec_size,
  output logic                       start_exec,
  output logic                       start_exec_shifted,
  output logic [AW-1:0]              addr_cmem,
  output logic [VEC_WIDTH_BITS-1:0]  vec_counter,
  output logic                       clken_vec,
  input  logic                       exec_end
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  seq_state_e state_q, state_d;
  logic       loaded_q;
  logic [AW-1:0] loop_start_q;
  logic [FC_W-1:0] flush_cnt_q;
  logic       hs;
  logic       vec_last;

  assign cfg_ready = chip_en && (state_q == IDLE);
  assign hs        = cfg_valid && cfg_ready;
  assign busy      = (state_q == LOAD) || (state_q == START) ||
                     (state_q == RUN)  || (state_q == FLUSH);
  assign clken_vec = (state_q != RUN) || vec_last;

  // Sequencer transitions; everything holds while chip_en is low.
  always_comb begin
    state_d = state_q;
    if (chip_en) begin
      case (state_q)
        IDLE:    if (hs) state_d = LOAD;
                 else if (go && loaded_q) state_d = START;
        LOAD:    state_d = IDLE;
        START:   state_d = abort ? FLUSH : RUN;
        RUN:     if (abort || exec_end) state_d = FLUSH;
        FLUSH:   if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, captured configuration, registered strobes and run statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= IDLE;
      loaded_q           <= 1'b0;
      configuration      <= '0;
      loop_start_q       <= '0;
      loop_end           <= '0;
      vec_size           <= '0;
      wr_en              <= 1'b0;
      done               <= 1'b0;
      start_exec         <= 1'b0;
      start_exec_shifted <= 1'b0;
      run_cycles         <= '0;
      flush_cnt_q        <= '0;
    end else if (!chip_en) begin
      wr_en <= 1'b0;
      done  <= 1'b0;
    end else begin
      state_q            <= state_d;
      wr_en              <= (state_d == LOAD);
      done               <= (state_d == DONE);
      start_exec         <= (state_d == START) || (state_d == RUN);
      start_exec_shifted <= (state_d == RUN);
      if (hs) begin
        configuration <= cfg_data;
        loop_start_q  <= cfg_loop_start;
        loop_end      <= cfg_loop_end;
        vec_size      <= cfg_vec_size;
        loaded_q      <= 1'b1;
      end
      if (state_q == START)
        run_cycles <= '0;
      else if (state_q == RUN)
        run_cycles <= sat_inc32(run_cycles);
      flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + FC_W'(1) : '0;
    end
  end

  loop_addr_gen #(
    .AW (AW),
    .VW (VEC_WIDTH_BITS),
    .EW (CONFIG_MEM_BITS)
  ) u_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .en_i         (chip_en),
    .clear_i      (state_d == FLUSH),
    .load_i       (state_q == START),
    .step_i       (state_q == RUN),
    .loop_start_i (loop_start_q),
    .loop_end_i   (loop_end),
    .vec_size_i   (vec_size),
    .addr_o       (addr_cmem),
    .vec_o        (vec_counter),
    .last_o       (vec_last)
  );

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        chip_en = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [33:0] cfg_data = '0;
  logic [3:0]  cfg_loop_start = '0;
  logic [2:0]  cfg_loop_end = '0;
  logic [1:0]  cfg_vec_size = '0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] run_cycles;
  logic [33:0] configuration;
  logic        wr_en;
  logic [2:0]  loop_end;
  logic [1:0]  vec_size;
  logic        start_exec, start_exec_shifted;
  logic [3:0]  addr_cmem;
  logic [1:0]  vec_counter;
  logic        clken_vec;
  logic        exec_end = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [1:0]  vec;
    logic        clken;
    logic [31:0] rc;
  } exp_t;

  exp_t        run_q[$];
  logic [33:0] cfg_q[$];
  logic [31:0] rc_q[$];

  exec_sequencer dut (
    .clk                (clk),
    .rstn               (rstn),
    .chip_en            (chip_en),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_data           (cfg_data),
    .cfg_loop_start     (cfg_loop_start),
    .cfg_loop_end       (cfg_loop_end),
    .cfg_vec_size       (cfg_vec_size),
    .go                 (go),
    .abort              (abort),
    .busy               (busy),
    .done               (done),
    .run_cycles         (run_cycles),
    .configuration      (configuration),
    .wr_en              (wr_en),
    .loop_end           (loop_end),
    .vec_size           (vec_size),
    .start_exec         (start_exec),
    .start_exec_shifted (start_exec_shifted),
    .addr_cmem          (addr_cmem),
    .vec_counter        (vec_counter),
    .clken_vec          (clken_vec),
    .exec_end           (exec_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    checks++;
    if ({cfg_ready, clken_vec, busy, done, wr_en, start_exec, start_exec_shifted} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1100000",
               {cfg_ready, clken_vec, busy, done, wr_en, start_exec, start_exec_shifted});
    end
    checks++;
    if ({run_cycles, configuration, addr_cmem, vec_counter, loop_end, vec_size} !== '0) begin
      errors++;
      $display("FAIL reset_data: run_cycles=%0d cfg=%h addr=%0d vec=%0d expected all 0",
               run_cycles, configuration, addr_cmem, vec_counter);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_go_unloaded();
    go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, start_exec} !== 2'b00) begin
        errors++;
        $display("FAIL go_unloaded: busy,start=%b expected 00", {busy, start_exec});
      end
      step();
    end
  endtask

  task automatic test_load(input logic [33:0] d, input logic [3:0] ls,
                           input logic [2:0] le, input logic [1:0] vs, input bit with_go);
    logic [33:0] e;
    cfg_data = d;
    cfg_loop_start = ls;
    cfg_loop_end = le;
    cfg_vec_size = vs;
    cfg_valid = 1'b1;
    go = with_go;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_idle: cfg_ready=%b expected 1", cfg_ready);
    end
    cfg_q.push_back(d);
    step();
    cfg_valid = 1'b0;
    go = 1'b0;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL load_wr_en: wr_en=%b expected 1", wr_en);
      cfg_q.delete();
    end else begin
      e = cfg_q.pop_front();
      checks++;
      if (configuration !== e) begin
        errors++;
        $display("FAIL load_config: got %h expected %h", configuration, e);
      end
    end
    checks++;
    if ({cfg_ready, busy, loop_end, vec_size} !== {1'b0, 1'b1, le, vs}) begin
      errors++;
      $display("FAIL load_status: ready=%b busy=%b le=%0d vs=%0d expected 0 1 %0d %0d",
               cfg_ready, busy, loop_end, vec_size, le, vs);
    end
    step();
    checks++;
    if ({wr_en, cfg_ready, busy, start_exec} !== 4'b0100) begin
      errors++;
      $display("FAIL load_after: wr_en,ready,busy,start=%b expected 0100",
               {wr_en, cfg_ready, busy, start_exec});
    end
  endtask

  task automatic test_run(input logic [3:0] ls, input logic [2:0] le, input logic [1:0] vs,
                          input int n, input bit use_abort, input int freeze_at);
    logic [3:0] m_addr;
    logic [1:0] m_vec;
    exp_t       e;
    int         cnt;
    logic [31:0] erc;
    m_addr = ls;
    m_vec = 2'd0;
    for (int k = 1; k <= n; k++) begin
      e.addr = m_addr;
      e.vec = m_vec;
      e.clken = (m_vec == vs);
      e.rc = 32'(k - 1);
      run_q.push_back(e);
      if (m_vec == vs) begin
        m_vec = 2'd0;
        if ((m_addr >= {1'b0, le}) || (m_addr < ls)) m_addr = ls;
        else m_addr = m_addr + 4'd1;
      end else begin
        m_vec = m_vec + 2'd1;
      end
    end
    rc_q.push_back(32'(n));

    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if ({start_exec, start_exec_shifted, busy} !== 3'b101) begin
      errors++;
      $display("FAIL run_start: start,shifted,busy=%b expected 101",
               {start_exec, start_exec_shifted, busy});
    end
    step();
    for (int k = 1; k <= n; k++) begin
      e = run_q.pop_front();
      checks++;
      if ({addr_cmem, vec_counter, clken_vec, run_cycles} !== {e.addr, e.vec, e.clken, e.rc}) begin
        errors++;
        $display("FAIL run_cycle%0d: addr=%0d vec=%0d clken=%b rc=%0d expected %0d %0d %b %0d",
                 k, addr_cmem, vec_counter, clken_vec, run_cycles, e.addr, e.vec, e.clken, e.rc);
      end
      checks++;
      if ({start_exec, start_exec_shifted, busy} !== 3'b111) begin
        errors++;
        $display("FAIL run_strobes%0d: start,shifted,busy=%b expected 111",
                 k, {start_exec, start_exec_shifted, busy});
      end
      if (k == freeze_at) begin
        chip_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
          step();
          checks++;
          if ({addr_cmem, vec_counter, run_cycles, start_exec, wr_en, done} !==
              {e.addr, e.vec, e.rc, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL freeze%0d: addr=%0d vec=%0d rc=%0d start=%b expected %0d %0d %0d 1",
                     f, addr_cmem, vec_counter, run_cycles, start_exec, e.addr, e.vec, e.rc);
          end
        end
        chip_en = 1'b1;
      end
      if (k == n) begin
        if (use_abort) abort = 1'b1;
        else exec_end = 1'b1;
      end
      step();
      abort = 1'b0;
      exec_end = 1'b0;
    end

    cnt = 0;
    while (done !== 1'b1 && cnt < 8) begin
      checks++;
      if ({clken_vec, start_exec, start_exec_shifted, busy, addr_cmem, vec_counter} !==
          {4'b1001, 4'd0, 2'd0}) begin
        errors++;
        $display("FAIL flush%0d: clken=%b start=%b shifted=%b busy=%b addr=%0d vec=%0d expected 1 0 0 1 0 0",
                 cnt, clken_vec, start_exec, start_exec_shifted, busy, addr_cmem, vec_counter);
      end
      cnt++;
      step();
    end
    erc = rc_q.pop_front();
    checks++;
    if ({done, busy} !== 2'b10 || cnt != 2) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b flush_cycles=%0d expected 1 0 2", done, busy, cnt);
    end
    checks++;
    if (run_cycles !== erc) begin
      errors++;
      $display("FAIL run_cycles: got %0d expected %0d", run_cycles, erc);
    end
    step();
    checks++;
    if ({done, busy, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL done_after: done,busy,ready=%b expected 001", {done, busy, cfg_ready});
    end
  endtask

  task automatic test_async_reset();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({cfg_ready, clken_vec, busy, done, wr_en, start_exec, start_exec_shifted} !== 7'b1100000) begin
      errors++;
      $display("FAIL async_reset_ctrl: got %b expected 1100000",
               {cfg_ready, clken_vec, busy, done, wr_en, start_exec, start_exec_shifted});
    end
    checks++;
    if ({run_cycles, configuration, addr_cmem, vec_counter, loop_end, vec_size} !== '0) begin
      errors++;
      $display("FAIL async_reset_data: rc=%0d cfg=%h addr=%0d vec=%0d expected all 0",
               run_cycles, configuration, addr_cmem, vec_counter);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if ({busy, start_exec} !== 2'b00) begin
      errors++;
      $display("FAIL loaded_cleared: busy,start=%b expected 00", {busy, start_exec});
    end
  endtask

  initial begin
    test_reset();
    test_go_unloaded();
    test_load(34'h1_0000_0007, 4'd1, 3'd3, 2'd0, 1'b0);
    test_run(4'd1, 3'd3, 2'd0, 10, 1'b0, 0);
    test_load(34'h2_1234_5678, 4'd0, 3'd5, 2'd3, 1'b1);
    test_run(4'd0, 3'd5, 2'd3, 12, 1'b0, 0);
    test_run(4'd0, 3'd5, 2'd3, 9, 1'b1, 4);
    test_load(34'h3_FFFF_FFFF, 4'd6, 3'd2, 2'd1, 1'b0);
    test_run(4'd6, 3'd2, 2'd1, 6, 1'b0, 0);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
